// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl encodings and FSM state types.
// Used by alu_multicycle, alu_serial_shifter and the ALU decoder.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_AUIPC = 4'b1000;
  localparam logic [3:0] ALU_LUI   = 4'b1001;
  localparam logic [3:0] ALU_SLL   = 4'b1010;
  localparam logic [3:0] ALU_SRA   = 4'b1011;
  localparam logic [3:0] ALU_SRL   = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SH_LL,
    SH_RL,
    SH_RA
  } shift_t;

  function automatic logic is_shift(
    input logic [3:0] c
  );
    return (c == ALU_SLL) ||
           (c == ALU_SRA) ||
           (c == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Bit-serial shifter: one bit position per step, counter of remaining steps.
// done flags the step that performs the final shift.
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  shift_t          kind,
  input  logic [XLEN-1:0] din,
  input  logic [4:0]      amt,
  output logic [XLEN-1:0] nxt,
  output logic            done
);

  logic [XLEN-1:0] q;
  logic [4:0]      cnt;
  shift_t          kind_q;

  // Value after one more shift of the held operand.
  always_comb begin
    nxt = q;
    unique case (kind_q)
      SH_LL: nxt = {q[XLEN-2:0], 1'b0};
      SH_RL: nxt = {1'b0, q[XLEN-1:1]};
      SH_RA: nxt = {q[XLEN-1], q[XLEN-1:1]};
      default: nxt = q;
    endcase
  end

  assign done = step && (cnt == 5'd1);

  // Operand/counter load on accept, one shift per step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q      <= '0;
      cnt    <= '0;
      kind_q <= SH_LL;
    end else if (load) begin
      q      <= din;
      cnt    <= amt;
      kind_q <= kind;
    end else if (step && (cnt != 5'd0)) begin
      q   <= nxt;
      cnt <= cnt - 5'd1;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle ops registered on accept,
// shifts run serially one bit per cycle with a valid/ready handshake.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ALUControl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero,
  output logic            illegal
);

  state_t          state;
  logic [XLEN-1:0] y;
  logic            legal;
  logic            accept;
  logic            sh_load;
  logic            sh_step;
  logic            sh_done;
  logic [XLEN-1:0] sh_nxt;
  shift_t          sh_kind;
  logic [4:0]      shamt;

  assign shamt    = SrcB[4:0];
  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready && !flush;
  assign sh_load  = accept && is_shift(ALUControl)
                    && (shamt != 5'd0);
  assign sh_step  = (state == S_SHIFT) && !flush;

  // Single-cycle result; shamt-0 shifts pass SrcA through.
  always_comb begin
    y     = '0;
    legal = 1'b1;
    unique case (ALUControl)
      ALU_ADD:   y = SrcA + SrcB;
      ALU_SUB:   y = SrcA - SrcB;
      ALU_AND:   y = SrcA & SrcB;
      ALU_OR:    y = SrcA | SrcB;
      ALU_XOR:   y = SrcA ^ SrcB;
      ALU_SLT:   y = {{(XLEN-1){1'b0}},
                      $signed(SrcA) < $signed(SrcB)};
      ALU_SLTU:  y = {{(XLEN-1){1'b0}}, SrcA < SrcB};
      ALU_AUIPC: y = SrcA + SrcB;
      ALU_LUI:   y = SrcB;
      ALU_SLL,
      ALU_SRA,
      ALU_SRL:   y = SrcA;
      default: begin
        y     = '0;
        legal = 1'b0;
      end
    endcase
  end

  // Shift direction selected by the op code.
  always_comb begin
    sh_kind = SH_LL;
    unique case (ALUControl)
      ALU_SRL: sh_kind = SH_RL;
      ALU_SRA: sh_kind = SH_RA;
      default: sh_kind = SH_LL;
    endcase
  end

  alu_serial_shifter #(.XLEN(XLEN)) u_shift (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .step  (sh_step),
    .kind  (sh_kind),
    .din   (SrcA),
    .amt   (shamt),
    .nxt   (sh_nxt),
    .done  (sh_done)
  );

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      illegal   <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (sh_load) begin
              state <= S_SHIFT;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              ALUResult <= y;
              Zero      <= (y == '0);
              illegal   <= !legal;
            end
          end
        end
        S_SHIFT: begin
          if (sh_done) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            ALUResult <= sh_nxt;
            Zero      <= (sh_nxt == '0);
            illegal   <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed testbench for alu_multicycle.
// Hand-computed vectors, latency and handshake checks.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        illegal;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       nm;
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        il;
    int          lat;
  } vec_t;

  always #5 clk = ~clk;

  alu_multicycle #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .illegal    (illegal)
  );

  function automatic vec_t mk(
    input string nm, input logic [3:0] c,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] r, input logic z,
    input logic il, input int lat
  );
    vec_t v;
    v.nm = nm; v.c = c; v.a = a; v.b = b;
    v.r = r; v.z = z; v.il = il; v.lat = lat;
    return v;
  endfunction

  // Issue one op from IDLE, measure cycles to out_valid, consume it.
  task automatic do_op(
    input  logic [3:0]  c,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          lat,
    output logic [31:0] r,
    output logic        z,
    output logic        il
  );
    @(negedge clk);
    ALUControl = c; SrcA = a; SrcB = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r = ALUResult; z = Zero; il = illegal;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_vecs(input vec_t v[$]);
    int lat;
    logic [31:0] r;
    logic z, il;
    foreach (v[i]) begin
      do_op(v[i].c, v[i].a, v[i].b, lat, r, z, il);
      n_chk++;
      if (lat !== v[i].lat) begin
        n_fail++;
        $display("FAIL %s latency got %0d want %0d",
                 v[i].nm, lat, v[i].lat);
      end
      n_chk++;
      if (r !== v[i].r) begin
        n_fail++;
        $display("FAIL %s result got %h want %h",
                 v[i].nm, r, v[i].r);
      end
      n_chk++;
      if (z !== v[i].z) begin
        n_fail++;
        $display("FAIL %s zero got %b want %b",
                 v[i].nm, z, v[i].z);
      end
      n_chk++;
      if (il !== v[i].il) begin
        n_fail++;
        $display("FAIL %s illegal got %b want %b",
                 v[i].nm, il, v[i].il);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; ALUControl = 4'h0;
    SrcA = '0; SrcB = '0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    n_chk++;
    if ({out_valid, ALUResult, Zero, illegal} !==
        {1'b0, 32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state got v=%b r=%h z=%b il=%b want 0/0/1/0",
               out_valid, ALUResult, Zero, illegal);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_arith();
    vec_t v[$];
    v.push_back(mk("add_ovf", 4'b0000, 32'h7FFF_FFFF,
                   32'h1, 32'h8000_0000, 0, 0, 1));
    v.push_back(mk("sub_eq", 4'b0001, 32'd5, 32'd5,
                   32'h0, 1, 0, 1));
    v.push_back(mk("slt_neg", 4'b0101, 32'hFFFF_FFFF,
                   32'h1, 32'h1, 0, 0, 1));
    v.push_back(mk("sltu_big", 4'b0110, 32'hFFFF_FFFF,
                   32'h1, 32'h0, 1, 0, 1));
    v.push_back(mk("and", 4'b0010, 32'hF0F0_F0F0,
                   32'hFF00_FF00, 32'hF000_F000, 0, 0, 1));
    v.push_back(mk("or", 4'b0011, 32'hF0F0_F0F0,
                   32'hFF00_FF00, 32'hFFF0_FFF0, 0, 0, 1));
    v.push_back(mk("xor", 4'b0100, 32'hF0F0_F0F0,
                   32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0, 1));
    run_vecs(v);
  endtask

  task automatic test_shift();
    vec_t v[$];
    v.push_back(mk("sra4", 4'b1011, 32'h8000_0000,
                   32'd4, 32'hF800_0000, 0, 0, 5));
    v.push_back(mk("srl4", 4'b1100, 32'h8000_0000,
                   32'd4, 32'h0800_0000, 0, 0, 5));
    v.push_back(mk("sll31", 4'b1010, 32'h1,
                   32'd31, 32'h8000_0000, 0, 0, 32));
    v.push_back(mk("sll0", 4'b1010, 32'h1234,
                   32'h20, 32'h1234, 0, 0, 1));
    v.push_back(mk("srl_out", 4'b1100, 32'h1,
                   32'd1, 32'h0, 1, 0, 2));
    run_vecs(v);
  endtask

  task automatic test_illegal();
    vec_t v[$];
    v.push_back(mk("ill_f", 4'b1111, 32'd5, 32'd6,
                   32'h0, 1, 1, 1));
    v.push_back(mk("ill_7", 4'b0111, 32'd5, 32'd6,
                   32'h0, 1, 1, 1));
    v.push_back(mk("lui", 4'b1001, 32'hDEAD,
                   32'h1234_5000, 32'h1234_5000, 0, 0, 1));
    v.push_back(mk("auipc", 4'b1000, 32'h1000,
                   32'h2000, 32'h3000, 0, 0, 1));
    run_vecs(v);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    ALUControl = 4'b0000; SrcA = 32'd3; SrcB = 32'd4;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ALUControl = 4'b0001; SrcA = 32'd10; SrcB = 32'd1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({out_valid, ALUResult, in_ready} !==
          {1'b1, 32'd7, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_cyc%0d got v=%b r=%h rdy=%b want 1/7/0",
                 i, out_valid, ALUResult, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_chk++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL consume_idle got v=%b rdy=%b want 0/1",
               out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++;
    if ({out_valid, ALUResult} !== {1'b1, 32'd9}) begin
      n_fail++;
      $display("FAIL next_op got v=%b r=%h want 1/9",
               out_valid, ALUResult);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    int seen = 0;
    int lat;
    logic [31:0] r;
    logic z, il;
    @(negedge clk);
    ALUControl = 4'b1010; SrcA = 32'h1; SrcB = 32'd20;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_chk++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_idle got v=%b rdy=%b want 0/1",
               out_valid, in_ready);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL flush_no_valid got %0d want 0", seen);
    end
    do_op(4'b0000, 32'd1, 32'd1, lat, r, z, il);
    n_chk++;
    if ({lat, r} !== {32'd1, 32'd2}) begin
      n_fail++;
      $display("FAIL post_flush got lat=%0d r=%h want 1/2", lat, r);
    end
  endtask

  task automatic test_async_reset();
    int seen = 0;
    @(negedge clk);
    ALUControl = 4'b0000; SrcA = 32'd1; SrcB = 32'd2;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_done got %b want 1", out_valid);
    end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({out_valid, ALUResult, Zero} !== {1'b0, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_in_done got v=%b r=%h z=%b want 0/0/1",
               out_valid, ALUResult, Zero);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ALUControl = 4'b1010; SrcA = 32'h1; SrcB = 32'd10;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_chk++;
    if ({seen, in_ready} !== {32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_in_shift got seen=%0d rdy=%b want 0/1",
               seen, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_illegal();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
